// File: rtl/dispense_sequencer.sv
// Coin/can dispense sequencer: a small request FIFO feeding a pulse / acknowledge / gap
// actuator FSM. Lost requests and actuator timeouts are reported through sticky flags.
module dispense_sequencer #(
  parameter int DEPTH     = 4,
  parameter int PULSE_LEN = 8,
  parameter int GAP_LEN   = 4,
  parameter int TIMEOUT   = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic lr1,
  input  logic lr2,
  input  logic ll,
  input  logic act_done,
  output logic coin_out,
  output logic can_out,
  output logic busy,
  output logic full,
  output logic ovf,
  output logic fault
);

  // state      | meaning
  // S_IDLE     | waiting for a queued command; pops the head when one is present
  // S_PULSE    | actuator driven high for PULSE_LEN cycles
  // S_WAIT_ACK | actuator released, waiting up to TIMEOUT cycles for act_done
  // S_GAP      | GAP_LEN idle cycles before the second coin of a COIN2
  // S_HALT     | actuator timed out; queue still fills, leave only through reset

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int TMR_W = 10;

  localparam logic [1:0] CMD_CAN   = 2'b01;
  localparam logic [1:0] CMD_COIN1 = 2'b10;
  localparam logic [1:0] CMD_COIN2 = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_PULSE, S_WAIT_ACK, S_GAP, S_HALT} state_t;

  state_t           state, state_nx;
  logic [1:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [TMR_W-1:0] timer, timer_nx;
  logic [1:0]       coins, coins_nx;
  logic             is_can, is_can_nx;
  logic [1:0]       push_cmd, head;
  logic             pop, push, req_any, req_multi, fault_set, empty;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign busy  = (state != S_IDLE) || !empty;
  assign head  = mem[rd_ptr];

  // Only the highest-priority request of a cycle is queued; the rest are lost.
  always_comb begin
    push_cmd = CMD_COIN1;
    if (ll)       push_cmd = CMD_CAN;
    else if (lr2) push_cmd = CMD_COIN2;
  end

  assign req_any   = ll | lr2 | lr1;
  assign req_multi = (ll & (lr2 | lr1)) | (lr2 & lr1);
  assign push      = req_any && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_cmd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (req_multi || (req_any && !push)) ovf <= 1'b1;
    end
  end

  always_comb begin
    state_nx  = state;
    timer_nx  = timer;
    coins_nx  = coins;
    is_can_nx = is_can;
    pop       = 1'b0;
    fault_set = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          is_can_nx = (head == CMD_CAN);
          coins_nx  = (head == CMD_COIN2) ? 2'd2 : (head == CMD_COIN1) ? 2'd1 : 2'd0;
          timer_nx  = TMR_W'(PULSE_LEN - 1);
          state_nx  = S_PULSE;
        end
      end
      S_PULSE: begin
        if (timer == '0) begin
          timer_nx = TMR_W'(TIMEOUT - 1);
          state_nx = S_WAIT_ACK;
        end else begin
          timer_nx = timer - 1'b1;
        end
      end
      S_WAIT_ACK: begin
        if (act_done) begin
          coins_nx = (coins != 2'd0) ? coins - 2'd1 : coins;
          if (coins_nx != 2'd0) begin
            timer_nx = TMR_W'(GAP_LEN - 1);
            state_nx = S_GAP;
          end else begin
            state_nx = S_IDLE;
          end
        end else if (timer == '0) begin
          fault_set = 1'b1;
          state_nx  = S_HALT;
        end else begin
          timer_nx = timer - 1'b1;
        end
      end
      S_GAP: begin
        if (timer == '0) begin
          timer_nx = TMR_W'(PULSE_LEN - 1);
          state_nx = S_PULSE;
        end else begin
          timer_nx = timer - 1'b1;
        end
      end
      S_HALT: state_nx = S_HALT;
      default: state_nx = S_IDLE;
    endcase
  end

  // Drives are decoded from the next state so they are true flops aligned with S_PULSE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      timer    <= '0;
      coins    <= 2'd0;
      is_can   <= 1'b0;
      fault    <= 1'b0;
      coin_out <= 1'b0;
      can_out  <= 1'b0;
    end else begin
      state    <= state_nx;
      timer    <= timer_nx;
      coins    <= coins_nx;
      is_can   <= is_can_nx;
      if (fault_set) fault <= 1'b1;
      coin_out <= (state_nx == S_PULSE) && !is_can_nx;
      can_out  <= (state_nx == S_PULSE) && is_can_nx;
    end
  end

endmodule

// File: tb/tb_dispense_sequencer.sv
// Directed bench for dispense_sequencer with default parameters; inputs change and
// outputs are sampled on the falling edge, k counts rising edges after the request edge.
module tb_dispense_sequencer;

  logic clk, rst_n, lr1, lr2, ll, act_done;
  logic coin_out, can_out, busy, full, ovf, fault;
  int   total = 0;
  int   bad   = 0;

  dispense_sequencer #(.DEPTH(4), .PULSE_LEN(8), .GAP_LEN(4), .TIMEOUT(200)) dut (
    .clk(clk), .rst_n(rst_n), .lr1(lr1), .lr2(lr2), .ll(ll), .act_done(act_done),
    .coin_out(coin_out), .can_out(can_out), .busy(busy), .full(full),
    .ovf(ovf), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; lr1 = 1'b0; lr2 = 1'b0; ll = 1'b0; act_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; lr1 = 1'b0; lr2 = 1'b0; ll = 1'b0; act_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_coin", coin_out, 1'b0);
    chk("rst_can", can_out, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_fault", fault, 1'b0);
    rst_n = 1'b1;

    // can request, acknowledge three cycles after the pulse ends
    @(negedge clk); ll = 1'b1;
    @(negedge clk); ll = 1'b0;
    chk("t1_k0_can", can_out, 1'b0);
    chk("t1_k0_busy", busy, 1'b1);
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      chk($sformatf("t1_can_k%0d", k), can_out, (k <= 8));
      chk($sformatf("t1_coin_k%0d", k), coin_out, 1'b0);
      if (k == 11) begin chk("t1_busy_wait", busy, 1'b1); act_done = 1'b1; end
      if (k == 12) begin chk("t1_busy_done", busy, 1'b0); act_done = 1'b0; end
    end

    // two-coin request with act_done held high throughout
    @(negedge clk); lr2 = 1'b1; act_done = 1'b1;
    @(negedge clk); lr2 = 1'b0;
    chk("t2_k0_coin", coin_out, 1'b0);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      chk($sformatf("t2_coin_k%0d", k), coin_out, (k <= 8) || (k >= 14 && k <= 21));
      chk($sformatf("t2_can_k%0d", k), can_out, 1'b0);
      if (k == 22) chk("t2_busy_k22", busy, 1'b1);
      if (k == 23) chk("t2_busy_k23", busy, 1'b0);
    end
    chk("t2_ovf", ovf, 1'b0);

    // simultaneous can and one-coin request: only the can survives
    @(negedge clk); ll = 1'b1; lr1 = 1'b1;
    @(negedge clk); ll = 1'b0; lr1 = 1'b0;
    chk("t3_ovf", ovf, 1'b1);
    chk("t3_busy", busy, 1'b1);
    chk("t3_full", full, 1'b0);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      chk($sformatf("t3_can_k%0d", k), can_out, (k <= 8));
      chk($sformatf("t3_coin_k%0d", k), coin_out, 1'b0);
      if (k >= 10) chk($sformatf("t3_busy_k%0d", k), busy, 1'b0);
    end
    act_done = 1'b0;
    chk("t3_ovf_sticky", ovf, 1'b1);

    // fill the queue during a pulse, then push while full in a popping cycle
    do_reset();
    chk("t4_ovf_clear", ovf, 1'b0);
    @(negedge clk); lr1 = 1'b1;
    @(negedge clk); lr1 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) lr1 = 1'b1;
      if (k == 4) begin chk("t4_full_k4", full, 1'b0); chk("t4_ovf_k4", ovf, 1'b0); end
      if (k == 5) begin chk("t4_full_k5", full, 1'b1); chk("t4_ovf_k5", ovf, 1'b0); end
      if (k == 6) begin
        chk("t4_full_k6", full, 1'b1);
        chk("t4_ovf_k6", ovf, 1'b1);
        chk("t4_coin_k6", coin_out, 1'b1);
        lr1 = 1'b0;
        act_done = 1'b1;
      end
      if (k == 10) begin
        chk("t4_full_k10", full, 1'b1);
        chk("t4_coin_k10", coin_out, 1'b0);
        lr1 = 1'b1;
      end
      if (k == 11) begin
        chk("t4_full_k11", full, 1'b1);
        chk("t4_coin_k11", coin_out, 1'b1);
        lr1 = 1'b0;
      end
      if (k == 12) chk("t4_coin_k12", coin_out, 1'b1);
    end
    act_done = 1'b0;

    // no acknowledge: timeout exactly 200 cycles after entering WAIT_ACK
    do_reset();
    @(negedge clk); lr1 = 1'b1;
    @(negedge clk); lr1 = 1'b0;
    for (int k = 1; k <= 215; k++) begin
      @(negedge clk);
      chk($sformatf("t5_coin_k%0d", k), coin_out, (k <= 8));
      chk($sformatf("t5_fault_k%0d", k), fault, (k >= 209));
      if (k == 210) lr1 = 1'b1;
      if (k == 211) act_done = 1'b1;
      if (k == 213) chk("t5_full_k213", full, 1'b0);
      if (k == 214) lr1 = 1'b0;
    end
    chk("t5_full", full, 1'b1);
    chk("t5_busy", busy, 1'b1);
    chk("t5_can", can_out, 1'b0);
    act_done = 1'b0;

    // reset mid-pulse clears drives, flags and the queue immediately
    do_reset();
    chk("t6_fault_clear", fault, 1'b0);
    chk("t6_busy_clear", busy, 1'b0);
    @(negedge clk); lr2 = 1'b1;
    @(negedge clk); lr2 = 1'b0; lr1 = 1'b1;
    @(negedge clk);
    @(negedge clk); ll = 1'b1;
    @(negedge clk); ll = 1'b0; lr1 = 1'b0;
    @(negedge clk);
    chk("t6_coin_pre", coin_out, 1'b1);
    chk("t6_ovf_pre", ovf, 1'b1);
    chk("t6_busy_pre", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_coin_rst", coin_out, 1'b0);
    chk("t6_can_rst", can_out, 1'b0);
    chk("t6_busy_rst", busy, 1'b0);
    chk("t6_full_rst", full, 1'b0);
    chk("t6_ovf_rst", ovf, 1'b0);
    chk("t6_fault_rst", fault, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("t6_coin_after_k%0d", k), coin_out, 1'b0);
      chk($sformatf("t6_busy_after_k%0d", k), busy, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dispense_sequencer.md
DISPENSE_SEQUENCER -- requirements
Module: dispense_sequencer

Interface
REQ-001 Parameter DEPTH, 4, command FIFO entries (power of two, 2..16).
REQ-002 Parameter PULSE_LEN, 8, actuator drive length in CLK cycles (1..255).
REQ-003 Parameter GAP_LEN, 4, idle cycles between consecutive coin ejections (1..255).
REQ-004 Parameter TIMEOUT, 200, maximum cycles to wait for ACT_DONE (1..1023).
REQ-005 CLK  input  1  single clock; all state changes on posedge.
REQ-006 RST_N  input  1  reset, asynchronous, active-low.
REQ-007 LR1  input  1  one-cycle request: return one coin.
REQ-008 LR2  input  1  one-cycle request: return two coins.
REQ-009 LL  input  1  one-cycle request: release one can.
REQ-010 ACT_DONE  input  1  actuator acknowledge, level, sampled only in WAIT_ACK.
REQ-011 COIN_OUT  output  1  coin ejector drive.
REQ-012 CAN_OUT  output  1  can solenoid drive.
REQ-013 BUSY  output  1  high when FSM is not IDLE or FIFO is not empty.
REQ-014 FULL  output  1  FIFO holds DEPTH entries.
REQ-015 OVF  output  1  sticky: a request was lost (full FIFO or simultaneous request).
REQ-016 FAULT  output  1  sticky: actuator timeout occurred.

Function
REQ-017 Commands SHALL be encoded 2 bits: CAN=01, COIN1=10, COIN2=11; stored in a DEPTH-entry FIFO.
REQ-018 At most one request SHALL be pushed per cycle, priority LL > LR2 > LR1; any lower-priority request asserted in the same cycle SHALL be dropped and SHALL set OVF.
REQ-019 A request arriving while FULL SHALL be dropped and SHALL set OVF, except in a cycle where the FSM pops, in which case the push SHALL be accepted.
REQ-020 FIFO pointers SHALL wrap modulo DEPTH; the occupancy count SHALL range 0..DEPTH and never overflow or underflow.
REQ-021 FSM states SHALL be IDLE, PULSE, WAIT_ACK, GAP, HALT.
REQ-022 IDLE: if FIFO not empty, pop head; load remaining-coin counter with 1 (COIN1), 2 (COIN2) or 0 (CAN); go to PULSE next cycle.
REQ-023 PULSE: drive CAN_OUT (CAN) or COIN_OUT (coin) high for exactly PULSE_LEN consecutive cycles, then go to WAIT_ACK.
REQ-024 WAIT_ACK: outputs low; count cycles; on ACT_DONE=1, decrement coin counter if nonzero, then go to GAP if counter is still nonzero, else IDLE.
REQ-025 WAIT_ACK: if ACT_DONE has not been seen within TIMEOUT cycles, SHALL set FAULT and go to HALT.
REQ-026 GAP: outputs low for GAP_LEN cycles, then PULSE with the same actuator (COIN_OUT).
REQ-027 HALT: outputs low, no pops; FIFO continues to accept pushes; exit only by reset.
REQ-028 Latency: request pulse at cycle N into an empty, IDLE block SHALL give first actuator-high cycle at N+2.
REQ-029 COIN_OUT and CAN_OUT SHALL never be high in the same cycle; both SHALL be registered outputs.
REQ-030 ACT_DONE high outside WAIT_ACK SHALL be ignored.

Reset
REQ-031 While RST_N=0: state IDLE, FIFO empty, pointers and counters 0; COIN_OUT=0, CAN_OUT=0, BUSY=0, FULL=0, OVF=0, FAULT=0.
REQ-032 Reset asserted mid-operation SHALL immediately drive COIN_OUT and CAN_OUT low and discard all queued commands.

Verification
REQ-033 LL pulse, PULSE_LEN=8, ACT_DONE 3 cycles after pulse end -> CAN_OUT high cycles 2..9, BUSY low after return to IDLE, COIN_OUT never high.
REQ-034 LR2 pulse, GAP_LEN=4, immediate ACT_DONE -> two 8-cycle COIN_OUT pulses separated by WAIT_ACK plus 4 gap cycles.
REQ-035 LL and LR1 in the same cycle -> only CAN dispensed, OVF=1, FIFO count 1.
REQ-036 Five LR1 pulses while first command is in PULSE (DEPTH=4) -> FULL=1 after fourth push, fifth dropped only if no pop that cycle, OVF=1.
REQ-037 ACT_DONE held low, TIMEOUT=200 -> FAULT=1 exactly 200 cycles after WAIT_ACK entry, no further actuator pulses, new requests still fill FIFO.
REQ-038 RST_N low during COIN_OUT pulse -> COIN_OUT low asynchronously, all flags and FIFO cleared, BUSY=0.
